mor1kx_pic_irq: RTL and testbench



---
 rtl/mor1kx_pic_irq.sv | 180 ++++++++++++++++++
 tb/tb_mor1kx_pic_irq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_pic_irq.sv
// mor1kx_pic_irq
// Programmable interrupt controller plus interrupt-request sequencer.
// Owns PICMR/PICSR, conditions the external interrupt lines and merges
// tick-timer and external interrupts into one exception request.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   irq_i               external interrupt lines (NUM_IRQ wide)
//   spr_ttmr_i          tick timer TTMR (bit 29 = IE, bit 28 = IP)
//   spr_sr_iee_i        SR[IEE] external interrupt enable
//   spr_sr_tee_i        SR[TEE] tick timer exception enable
//   spr_we_i/addr/dat   SPR write port (PICMR = 0x4800, PICSR = 0x4802)
//   spr_bus_ack         always 1
//   spr_dat_o           combinational PICMR/PICSR readback, 0 elsewhere
//   spr_picmr_o/picsr_o register views
//   exc_req_o/type_o    request toward exception control (type 0 = tick,
//                       1 = external)
//   exc_ack_i           request accepted
//   dbg_state_o         request FSM state (IDLE=0, REQ=1, WAIT=2)
//
// Handshake: exc_req_o rises with exc_type_o valid and both stay constant
// until exc_ack_i is sampled high while the request is up; the request is
// never withdrawn before that. exc_ack_i at any other time has no effect.
module mor1kx_pic_irq #(
  parameter int    NUM_IRQ            = 32,
  parameter string OPTION_PIC_TRIGGER = "LEVEL",
  parameter string OPTION_PIC_SYNC    = "ENABLED"
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [31:0]        spr_ttmr_i,
  input  logic               spr_sr_iee_i,
  input  logic               spr_sr_tee_i,
  input  logic               spr_we_i,
  input  logic [15:0]        spr_addr_i,
  input  logic [31:0]        spr_dat_i,
  output logic               spr_bus_ack,
  output logic [31:0]        spr_dat_o,
  output logic [31:0]        spr_picmr_o,
  output logic [31:0]        spr_picsr_o,
  output logic               exc_req_o,
  output logic               exc_type_o,
  input  logic               exc_ack_i,
  output logic [1:0]         dbg_state_o
);

  localparam logic [15:0] PICMR_ADDR = 16'h4800;
  localparam logic [15:0] PICSR_ADDR = 16'h4802;
  // Implemented lines only; bits above NUM_IRQ-1 can never be set.
  localparam logic [31:0] IRQ_MASK   = 32'hffff_ffff >> (32 - NUM_IRQ);
  localparam bit          EDGE_MODE  = (OPTION_PIC_TRIGGER == "EDGE");

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  logic [31:0] irq_w;
  logic [31:0] irq_s;
  logic [31:0] picmr_q, picmr_d;
  logic [31:0] picsr_q, picsr_d;
  logic [31:0] prev_q;
  logic [31:0] rise;
  logic [31:0] clr;
  logic        picmr_we, picsr_we;
  logic        tt_pend, ext_pend;
  state_e      state_q;
  logic        req_q;
  logic        type_q;
  logic [29:0] unused_ttmr;

  // Widen the external lines to the 32-bit SPR width.
  genvar gi;
  for (gi = 0; gi < 32; gi++) begin : g_ext
    if (gi < NUM_IRQ) begin : g_on
      assign irq_w[gi] = irq_i[gi];
    end else begin : g_off
      assign irq_w[gi] = 1'b0;
    end
  end

  if (OPTION_PIC_SYNC == "ENABLED") begin : g_sync
    logic [31:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q <= '0;
        sync2_q <= '0;
      end else begin
        sync1_q <= irq_w;
        sync2_q <= sync1_q;
      end
    end
    assign irq_s = sync2_q;
  end else begin : g_nosync
    assign irq_s = irq_w;
  end

  assign picmr_we = spr_we_i && (spr_addr_i == PICMR_ADDR);
  assign picsr_we = spr_we_i && (spr_addr_i == PICSR_ADDR);

  always_comb begin
    picmr_d = picmr_we ? (spr_dat_i & IRQ_MASK) : picmr_q;
    rise    = irq_s & ~prev_q;
    clr     = picsr_we ? spr_dat_i : '0;
    if (EDGE_MODE) begin
      // Clear is applied first so a same-cycle rise re-sets the bit.
      picsr_d = (picsr_q & ~clr) | (rise & picmr_q);
    end else begin
      picsr_d = irq_s & picmr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      picmr_q <= '0;
      picsr_q <= '0;
      prev_q  <= '0;
    end else begin
      picmr_q <= picmr_d;
      picsr_q <= picsr_d;
      prev_q  <= irq_s;
    end
  end

  assign tt_pend  = spr_ttmr_i[29] & spr_ttmr_i[28] & spr_sr_tee_i;
  assign ext_pend = (|picsr_q) & spr_sr_iee_i;
  assign unused_ttmr = {spr_ttmr_i[31:30], spr_ttmr_i[27:0]};

  // Request sequencer. WAIT blocks a new request of the same source until
  // the handler (or exception entry) has dropped its pending/enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      type_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tt_pend || ext_pend) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            type_q  <= ~tt_pend;  // tick wins when both are pending
          end
        end
        ST_REQ: begin
          if (exc_ack_i) begin
            state_q <= ST_WAIT;
            req_q   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (type_q ? !ext_pend : !tt_pend) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign exc_req_o   = req_q;
  assign exc_type_o  = type_q;
  assign dbg_state_o = state_q;

  assign spr_bus_ack = 1'b1;
  assign spr_picmr_o = picmr_q;
  assign spr_picsr_o = picsr_q;

  always_comb begin
    spr_dat_o = '0;
    if (spr_addr_i == PICMR_ADDR) spr_dat_o = picmr_q;
    else if (spr_addr_i == PICSR_ADDR) spr_dat_o = picsr_q;
  end

endmodule

// File: tb/tb_mor1kx_pic_irq.sv
// Bench for mor1kx_pic_irq. Two instances share all inputs:
//   u_lvl : 8 lines, LEVEL trigger, 2-flop synchronizer
//   u_edg : 8 lines, EDGE trigger, no synchronizer
// Each cycle the stimulus side pushes the expected outputs of both
// instances (from a rule-level reference model) onto exp_q; a monitor on
// the falling edge pops one entry and compares it with the DUT outputs.
module tb_mor1kx_pic_irq;

  localparam int W = 196;  // two 98-bit blocks {req,type,picmr,picsr,dat}

  logic        clk;
  logic        rst;
  logic [7:0]  irq;
  logic [31:0] ttmr;
  logic        iee, tee, we, ack;
  logic [15:0] addr;
  logic [31:0] dat;

  logic        l_back, l_req, l_type;
  logic [31:0] l_dat, l_mr, l_sr;
  logic [1:0]  l_st;
  logic        e_back, e_req, e_type;
  logic [31:0] e_dat, e_mr, e_sr;
  logic [1:0]  e_st;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // reference model state, index 0 = level/sync, 1 = edge/no-sync
  logic [31:0] m_s1[2], m_s2[2], m_prev[2], m_mr[2], m_sr[2];
  logic        m_req[2], m_kind[2], m_blk[2];

  mor1kx_pic_irq #(.NUM_IRQ(8), .OPTION_PIC_TRIGGER("LEVEL"), .OPTION_PIC_SYNC("ENABLED")) u_lvl (
    .clk(clk), .rst(rst), .irq_i(irq), .spr_ttmr_i(ttmr),
    .spr_sr_iee_i(iee), .spr_sr_tee_i(tee), .spr_we_i(we),
    .spr_addr_i(addr), .spr_dat_i(dat), .spr_bus_ack(l_back),
    .spr_dat_o(l_dat), .spr_picmr_o(l_mr), .spr_picsr_o(l_sr),
    .exc_req_o(l_req), .exc_type_o(l_type), .exc_ack_i(ack),
    .dbg_state_o(l_st)
  );

  mor1kx_pic_irq #(.NUM_IRQ(8), .OPTION_PIC_TRIGGER("EDGE"), .OPTION_PIC_SYNC("NONE")) u_edg (
    .clk(clk), .rst(rst), .irq_i(irq), .spr_ttmr_i(ttmr),
    .spr_sr_iee_i(iee), .spr_sr_tee_i(tee), .spr_we_i(we),
    .spr_addr_i(addr), .spr_dat_i(dat), .spr_bus_ack(e_back),
    .spr_dat_o(e_dat), .spr_picmr_o(e_mr), .spr_picsr_o(e_sr),
    .exc_req_o(e_req), .exc_type_o(e_type), .exc_ack_i(ack),
    .dbg_state_o(e_st)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Advances both models by one clock edge using the inputs present at it.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] irq_in, irq_s, sr_old, clr;
      logic tt, ex;
      if (rst) begin
        m_s1[k] = 0; m_s2[k] = 0; m_prev[k] = 0; m_mr[k] = 0; m_sr[k] = 0;
        m_req[k] = 0; m_kind[k] = 0; m_blk[k] = 0;
      end else begin
        irq_in = {24'b0, irq};
        irq_s  = (k == 0) ? m_s2[k] : irq_in;  // sync: value seen two edges ago
        sr_old = m_sr[k];
        tt = ttmr[29] & ttmr[28] & tee;
        ex = (sr_old != 0) & iee;
        if (k == 0) begin
          m_sr[k] = irq_s & m_mr[k];
        end else begin
          clr = (we && addr == 16'h4802) ? dat : 32'h0;
          m_sr[k] = (sr_old & ~clr) | (irq_s & ~m_prev[k] & m_mr[k]);
        end
        m_prev[k] = irq_s;
        m_s2[k] = m_s1[k];
        m_s1[k] = irq_in;
        if (we && addr == 16'h4800) m_mr[k] = dat & 32'h0000_00ff;
        // request rules: outstanding until ack, then blocked until the
        // taken source (with its enable) is seen inactive
        if (m_blk[k]) begin
          if (m_kind[k] ? !ex : !tt) m_blk[k] = 0;
        end else if (m_req[k]) begin
          if (ack) begin m_req[k] = 0; m_blk[k] = 1; end
        end else if (tt || ex) begin
          m_req[k] = 1;
          m_kind[k] = tt ? 1'b0 : 1'b1;
        end
      end
    end
  endtask

  function automatic logic [97:0] exp_of(int k);
    logic [31:0] rb;
    rb = (addr == 16'h4800) ? m_mr[k] : (addr == 16'h4802) ? m_sr[k] : 32'h0;
    return {m_req[k], m_kind[k], m_mr[k], m_sr[k], rb};
  endfunction

  // ---------------- driver tasks ----------------
  // Called with the next inputs already driven; records what the DUTs must
  // show until the coming edge, then advances the model across that edge.
  task automatic tick();
    exp_q.push_back({exp_of(0), exp_of(1)});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; dat = d;
    tick();
    we = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [97:0] a, b;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = e[195:98];
      b = e[97:0];
      check("lvl_req",   {31'b0, l_req},  {31'b0, a[97]});
      check("lvl_type",  {31'b0, l_type}, {31'b0, a[96]});
      check("lvl_picmr", l_mr,  a[95:64]);
      check("lvl_picsr", l_sr,  a[63:32]);
      check("lvl_dat",   l_dat, a[31:0]);
      check("lvl_ack",   {31'b0, l_back}, 32'h1);
      check("edg_req",   {31'b0, e_req},  {31'b0, b[97]});
      check("edg_type",  {31'b0, e_type}, {31'b0, b[96]});
      check("edg_picmr", e_mr,  b[95:64]);
      check("edg_picsr", e_sr,  b[63:32]);
      check("edg_dat",   e_dat, b[31:0]);
      check("edg_ack",   {31'b0, e_back}, 32'h1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] addr_tab[4];
    logic [31:0] ttmr_tab[4];
    int wait_n;
    addr_tab = '{16'h4800, 16'h4802, 16'h5000, 16'h4801};
    ttmr_tab = '{32'h0, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};

    rst = 1'b1; irq = 8'hff; ttmr = 0; iee = 0; tee = 0;
    we = 0; ack = 0; addr = 16'h4800; dat = 0;
    @(posedge clk);
    model_step();
    #1;
    // reset held with all lines high
    run(2);
    rst = 1'b0; irq = 8'h00;
    run(3);

    // level external interrupt on line 2
    wr(16'h4800, 32'h4);
    iee = 1'b1; irq = 8'h04; addr = 16'h4802;
    run(6);
    ack = 1'b1; tick(); ack = 1'b0;
    run(2);
    iee = 1'b0; run(2);
    irq = 8'h00; run(4);

    // edge capture, rise-beats-clear, plain clear
    wr(16'h4800, 32'h1);
    irq = 8'h01; tick(); irq = 8'h00;
    run(3);
    irq = 8'h01; wr(16'h4802, 32'h1);
    run(2);
    wr(16'h4802, 32'h1);
    irq = 8'h00; run(4);

    // tick and external pending together, tick first
    irq = 8'h01; run(4);
    ttmr = 32'h3000_0000; tee = 1'b1; iee = 1'b1;
    run(3);
    ack = 1'b1; tick(); ack = 1'b0;
    tee = 1'b0; run(3);
    ack = 1'b1; tick(); ack = 1'b0;
    iee = 1'b0; irq = 8'h00; run(6);

    // request held after its enable drops
    ttmr = 32'h3000_0000; tee = 1'b1; run(2);
    tee = 1'b0; run(3);
    ack = 1'b1; tick(); ack = 1'b0;
    run(2); ttmr = 0; run(2);

    // masking, unmapped readback, upper PICMR bits
    wr(16'h4800, 32'h0);
    irq = 8'hff; iee = 1'b1; addr = 16'h5000; run(5);
    wr(16'h4800, 32'hffff_ffff);
    run(5);
    rst = 1'b1; tick(); rst = 1'b0;
    irq = 8'h00; iee = 1'b0; run(3);

    // randomized phase
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) irq[$urandom_range(0, 7)] = ~irq[$urandom_range(0, 7)];
      if ($urandom_range(0, 12) == 0) iee = ~iee;
      if ($urandom_range(0, 12) == 0) tee = ~tee;
      if ($urandom_range(0, 12) == 0) ttmr = ttmr_tab[$urandom_range(0, 3)];
      we   = ($urandom_range(0, 5) == 0);
      addr = addr_tab[$urandom_range(0, 3)];
      dat  = ($urandom_range(0, 1) == 0) ? $urandom : {24'b0, 8'($urandom_range(0, 255))};
      ack  = ($urandom_range(0, 2) == 0);
      rst  = (c == 750);
      tick();
    end
    rst = 1'b0; we = 1'b0; ack = 1'b0;

    // drain the scoreboard, bounded
    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
    end
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
